// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Per-phase countdown timer for the intersection traffic controller. The
//   controller raises load_counter on the cycle of a state change; the timer
//   clears to 0 and loads load_value on the following edge. It then counts
//   down once per TICK_DIV clocks while en is high, and parks at 1. The
//   controller treats counter_value == 1 as phase expiry.
//
// Handshake:
//   load_counter is level-sampled on every edge and is not acknowledged. A
//   high sample always wins over anything else that edge would have done.
//   load_value is sampled on the edge after the request, which is the first
//   edge that sees load_counter low again.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   load_counter  in   load request, level-sampled each edge
//   load_value    in   phase duration in seconds (CW bits)
//   en            in   count enable; low freezes the prescaler and the count
//   counter_value out  remaining seconds; 0 while a load is pending
//   tick          out  one-cycle pulse on each decrement
//   expired       out  one-cycle pulse when counter_value becomes 1
//   holding       out  high while parked at 1
//   dbg_state     out  current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int CW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_counter,
  input  logic [CW-1:0] load_value,
  input  logic          en,
  output logic [CW-1:0] counter_value,
  output logic          tick,
  output logic          expired,
  output logic          holding,
  output logic [1:0]    dbg_state
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_PEND  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_expired;
  logic          r_holding;

  state_t        w_state;
  logic [CW-1:0] w_cnt;
  logic [PW-1:0] w_presc;
  logic          w_tick;
  logic          w_expired;
  logic [CW-1:0] w_load_val;
  logic [CW-1:0] w_dec;
  logic          w_wrap;

  // A zero duration is clamped to 1 so the controller still sees expiry.
  assign w_load_val = (load_value == '0) ? CW'(1) : load_value;
  assign w_dec      = r_cnt - CW'(1);
  assign w_wrap     = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_PEND;
      r_cnt     <= '0;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_expired <= 1'b0;
      r_holding <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_presc   <= w_presc;
      r_tick    <= w_tick;
      r_expired <= w_expired;
      r_holding <= (w_state == S_HOLD);
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_presc   = r_presc;
    w_tick    = 1'b0;
    w_expired = 1'b0;

    if (load_counter) begin
      // Showing 0 during the pending cycle keeps the controller from
      // retransitioning before the new duration arrives.
      w_state = S_PEND;
      w_cnt   = '0;
      w_presc = '0;
    end else begin
      case (r_state)
        S_PEND: begin
          w_cnt   = w_load_val;
          w_presc = '0;
          if (w_load_val == CW'(1)) begin
            w_state   = S_HOLD;
            w_expired = 1'b1;
          end else begin
            w_state = S_COUNT;
          end
        end
        S_COUNT: begin
          if (en) begin
            if (w_wrap) begin
              w_presc = '0;
              w_cnt   = w_dec;
              w_tick  = 1'b1;
              if (w_dec == CW'(1)) begin
                w_expired = 1'b1;
                w_state   = S_HOLD;
              end
            end else begin
              w_presc = r_presc + PW'(1);
            end
          end
        end
        S_HOLD: begin
          w_cnt   = CW'(1);
          w_presc = '0;
        end
        default: begin
          w_state = S_PEND;
          w_cnt   = '0;
          w_presc = '0;
        end
      endcase
    end
  end

  assign counter_value = r_cnt;
  assign tick          = r_tick;
  assign expired       = r_expired;
  assign holding       = r_holding;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_phase_timer
//   Self-checking bench for phase_timer with TICK_DIV=4, CW=5. A reference
//   model tracks the phase as "seconds remaining" plus "enabled cycles spent
//   in the current second" and predicts the outputs after every edge.
// -----------------------------------------------------------------------------
module tb_phase_timer;

  localparam int TICK_DIV = 4;
  localparam int CW       = 5;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_counter;
  logic [CW-1:0] load_value;
  logic          en;
  logic [CW-1:0] counter_value;
  logic          tick;
  logic          expired;
  logic          holding;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  phase_timer #(.TICK_DIV(TICK_DIV), .CW(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_counter  (load_counter),
    .load_value    (load_value),
    .en            (en),
    .counter_value (counter_value),
    .tick          (tick),
    .expired       (expired),
    .holding       (holding),
    .dbg_state     (dbg_state)
  );

  // scoreboard
  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  bit m_pending;
  int m_secs;
  int m_elapsed;
  bit m_tick;
  bit m_exp;

  task automatic model_reset();
    m_pending = 1'b1;
    m_secs    = 0;
    m_elapsed = 0;
    m_tick    = 1'b0;
    m_exp     = 1'b0;
  endtask

  task automatic model_edge(input bit lc, input int lv, input bit e);
    m_tick = 1'b0;
    m_exp  = 1'b0;
    if (lc) begin
      m_pending = 1'b1;
      m_secs    = 0;
      m_elapsed = 0;
    end else if (m_pending) begin
      m_pending = 1'b0;
      m_secs    = (lv < 1) ? 1 : lv;
      m_elapsed = 0;
      m_exp     = (m_secs == 1);
    end else if (m_secs > 1 && e) begin
      m_elapsed++;
      if (m_elapsed == TICK_DIV) begin
        m_elapsed = 0;
        m_secs--;
        m_tick = 1'b1;
        m_exp  = (m_secs == 1);
      end
    end
  endtask

  task automatic push_expect();
    exp_q.push_back(32'(m_secs));
    exp_q.push_back(32'(m_tick));
    exp_q.push_back(32'(m_exp));
    exp_q.push_back(32'(!m_pending && m_secs == 1));
  endtask

  task automatic check_outputs();
    check_eq("counter_value", counter_value, exp_q.pop_front());
    check_eq("tick",          tick,          exp_q.pop_front());
    check_eq("expired",       expired,       exp_q.pop_front());
    check_eq("holding",       holding,       exp_q.pop_front());
  endtask

  // driver: apply inputs, take one edge, update model, compare at edge+1
  task automatic step(input bit lc, input logic [CW-1:0] lv, input bit e);
    load_counter = lc;
    load_value   = lv;
    en           = e;
    @(posedge clk);
    model_edge(lc, int'(lv), e);
    push_expect();
    #1;
    check_outputs();
  endtask

  task automatic load(input logic [CW-1:0] lv);
    step(1'b1, lv, 1'b1);
    step(1'b0, lv, 1'b1);
  endtask

  initial begin
    int n;
    bit seen;

    rst_n        = 1'b0;
    load_counter = 1'b0;
    load_value   = 5'd30;
    en           = 1'b1;
    model_reset();
    #12;
    push_expect();
    check_outputs();

    // 1: reset release loads 30 with no request; expiry 116 cycles later
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 5'd30, 1'b1);
    check_eq("first_load", counter_value, 30);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      step(1'b0, 5'd30, 1'b1);
      n++;
      seen = expired;
    end
    check_eq("expire_latency", n, 116);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd30, 1'b1);
    check_eq("hold_parked", holding, 1);

    // 2: load_value sampled the cycle after the request
    step(1'b1, 5'd30, 1'b1);
    check_eq("pending_zero", counter_value, 0);
    step(1'b0, 5'd3, 1'b1);
    check_eq("late_sample", counter_value, 3);
    for (int i = 0; i < 12; i++) step(1'b0, 5'd3, 1'b1);
    check_eq("reload_hold", holding, 1);

    // 3: freeze at 10 with the prescaler part-way through a second
    load(5'd12);
    n = 0;
    while (counter_value != 5'd10 && n < 50) begin
      step(1'b0, 5'd12, 1'b1);
      n++;
    end
    check_eq("reach10", counter_value, 10);
    step(1'b0, 5'd12, 1'b1);
    step(1'b0, 5'd12, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 5'd12, 1'b0);
    check_eq("frozen", counter_value, 10);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      step(1'b0, 5'd12, 1'b1);
      n++;
      seen = tick;
    end
    check_eq("resume_cycles", n, 2);
    check_eq("resume_value", counter_value, 9);

    // 4: zero and one durations go straight to HOLD
    load(5'd0);
    check_eq("load0_val", counter_value, 1);
    check_eq("load0_exp", expired, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 1'b1);
    load(5'd1);
    check_eq("load1_val", counter_value, 1);
    check_eq("load1_hold", holding, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 5'd1, 1'b1);

    // 5: request on the edge that would tick 2 -> 1
    load(5'd3);
    n = 0;
    while (!(m_secs == 2 && m_elapsed == TICK_DIV - 1) && n < 50) begin
      step(1'b0, 5'd3, 1'b1);
      n++;
    end
    step(1'b1, 5'd9, 1'b1);
    check_eq("collide_tick", tick, 0);
    check_eq("collide_val", counter_value, 0);
    step(1'b0, 5'd9, 1'b1);
    check_eq("collide_load", counter_value, 9);

    // 6: asynchronous reset mid-count
    load(5'd20);
    n = 0;
    while (counter_value != 5'd17 && n < 50) begin
      step(1'b0, 5'd20, 1'b1);
      n++;
    end
    check_eq("reach17", counter_value, 17);
    step(1'b0, 5'd20, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    push_expect();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 5'd25, 1'b1);
    check_eq("post_reset_load", counter_value, 25);

    // 7: randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit          r_lc;
      logic [CW-1:0] r_lv;
      bit          r_en;
      r_lc = ($urandom_range(0, 24) == 0);
      r_lv = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 31))
                                         : CW'($urandom_range(0, 6));
      r_en = ($urandom_range(0, 7) != 0);
      step(r_lc, r_lv, r_en);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
